// File: rtl/poly_osc.sv
// poly_osc: N_CH independent square/pulse tone oscillators tuned by MIDI note,
// with glitch-free retune at period boundaries and a registered voice count.
module poly_osc #(
  parameter  int N_CH     = 4,
  parameter  int CNT_BW   = 16,
  parameter  int F_CLK_HZ = 1_000_000,
  localparam int CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int MIX_W    = $clog2(N_CH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_en_i,
  input  logic [CH_W-1:0]   wr_ch_i,
  input  logic [7:0]        wr_note_i,
  input  logic              wr_mode_i,
  input  logic [7:0]        wr_duty_i,
  input  logic [N_CH-1:0]   en_i,
  input  logic [N_CH-1:0]   phase_rst_i,
  output logic [N_CH-1:0]   wave_o,
  output logic [MIX_W-1:0]  mix_o
);

  // Equal-tempered period in clock cycles, evaluated only at elaboration.
  function automatic logic [CNT_BW-1:0] calc_period(input int n);
    real freq;
    real cycles;
    freq   = 440.0 * (2.0 ** ((real'(n) - 69.0) / 12.0));
    cycles = real'(F_CLK_HZ) / freq;
    if (cycles >= (2.0 ** CNT_BW) - 1.0) return '1;
    return CNT_BW'($rtoi(cycles));
  endfunction

  function automatic logic [6:0] clamp_note(input logic [7:0] n);
    if (n < 8'd21)  return 7'd21;
    if (n > 8'd127) return 7'd127;
    return n[6:0];
  endfunction

  localparam logic [CNT_BW-1:0] P_DEF = calc_period(69);
  localparam logic [CNT_BW-1:0] T_DEF = P_DEF >> 1;

  logic [CNT_BW-1:0] period_tab [128];

  for (genvar n = 0; n < 128; n++) begin : g_tab
    localparam logic [CNT_BW-1:0] P_N = calc_period(n);
    assign period_tab[n] = P_N;
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    logic [6:0]        note_q;
    logic              mode_q;
    logic [7:0]        duty_q;
    logic [CNT_BW-1:0] cnt_q;
    logic [CNT_BW-1:0] p_q;
    logic [CNT_BW-1:0] t_q;
    logic [CNT_BW-1:0] p_nxt;
    logic [CNT_BW-1:0] t_nxt;
    logic [CNT_BW+7:0] prod;
    logic              wave_q;
    logic              en_q;
    logic              pend_q;
    logic              wr_hit;
    logic              wrap;
    logic              restart;

    // Out-of-range channel numbers never match any k, so they are dropped here.
    assign wr_hit  = wr_en_i && (wr_ch_i == CH_W'(k));
    assign wrap    = (p_q == '0) || (cnt_q >= p_q - CNT_BW'(1));
    assign restart = pend_q || (phase_rst_i[k] && !wr_hit);

    always_comb begin
      p_nxt = period_tab[note_q];
      prod  = (CNT_BW+8)'(p_nxt) * (CNT_BW+8)'(duty_q);
      t_nxt = mode_q ? CNT_BW'(prod >> 8) : (p_nxt >> 1);
    end

    // NOTE: the config storage is a handful of flops with a defined power-on
    // value, so it is reset like any other state rather than left as a memory.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        note_q <= 7'd69;
        mode_q <= 1'b0;
        duty_q <= 8'd128;
      end else if (wr_hit) begin
        note_q <= clamp_note(wr_note_i);
        mode_q <= wr_mode_i;
        duty_q <= wr_duty_i;
      end
    end

    // NOTE: non-blocking assignments here so every register samples the
    // pre-edge value of cnt_q/t_q regardless of statement order.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        cnt_q  <= '0;
        p_q    <= P_DEF;
        t_q    <= T_DEF;
        wave_q <= 1'b0;
        en_q   <= 1'b0;
        pend_q <= 1'b0;
      end else begin
        en_q <= en_i[k];
        if (!en_i[k]) begin
          cnt_q  <= '0;
          wave_q <= 1'b0;
          pend_q <= 1'b0;
        end else if (!en_q) begin
          cnt_q  <= '0;
          p_q    <= p_nxt;
          t_q    <= t_nxt;
          wave_q <= 1'b0;
          pend_q <= 1'b0;
        end else begin
          wave_q <= (cnt_q < t_q);
          // A restart colliding with a write is deferred one cycle so it
          // picks up the freshly written shadow.
          pend_q <= phase_rst_i[k] && wr_hit;
          if (restart || wrap) begin
            cnt_q <= '0;
            p_q   <= p_nxt;
            t_q   <= t_nxt;
          end else begin
            cnt_q <= cnt_q + CNT_BW'(1);
          end
        end
      end
    end

    assign wave_o[k] = wave_q;
  end

  logic [MIX_W-1:0] ones;

  // NOTE: default assignment first so the combinational sum can never infer a latch.
  always_comb begin
    ones = '0;
    for (int i = 0; i < N_CH; i++) ones += MIX_W'(wave_o[i]);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) mix_o <= '0;
    else       mix_o <= ones;
  end

endmodule

// File: tb/tb_poly_osc.sv
// Directed bench for poly_osc: reset, tuning, pulse duty, glitch-free retune,
// write/restart collision, reset override and mix timing.
module tb_poly_osc;
  localparam int LIMIT = 40000;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [1:0] wr_ch;
  logic [7:0] wr_note;
  logic       wr_mode;
  logic [7:0] wr_duty;
  logic [3:0] en;
  logic [3:0] phase_rst;
  logic [3:0] wave;
  logic [2:0] mix;

  int checks   = 0;
  int failures = 0;
  int hi;
  int lo;

  always #5 clk = ~clk;

  poly_osc #(.N_CH(4), .CNT_BW(16), .F_CLK_HZ(1_000_000)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .wr_en_i     (wr_en),
    .wr_ch_i     (wr_ch),
    .wr_note_i   (wr_note),
    .wr_mode_i   (wr_mode),
    .wr_duty_i   (wr_duty),
    .en_i        (en),
    .phase_rst_i (phase_rst),
    .wave_o      (wave),
    .mix_o       (mix)
  );

  task automatic set_write(input int ch, input int note, input bit mode, input int duty);
    wr_en   = 1'b1;
    wr_ch   = 2'(ch);
    wr_note = 8'(note);
    wr_mode = mode;
    wr_duty = 8'(duty);
  endtask

  // Counts high then low samples of one period; at_rise means the current
  // sample is already the first high one. Timeout reports -1 for both.
  task automatic measure(input int ch, input bit at_rise, output int h, output int l);
    int n;
    h = 0;
    l = 0;
    n = 0;
    if (!at_rise) begin
      while (wave[ch] && n < LIMIT) begin @(negedge clk); n++; end
      while (!wave[ch] && n < LIMIT) begin @(negedge clk); n++; end
    end
    n = 0;
    while (wave[ch] && n < LIMIT) begin h++; @(negedge clk); n++; end
    while (!wave[ch] && n < LIMIT) begin l++; @(negedge clk); n++; end
    if (n >= LIMIT) begin h = -1; l = -1; end
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_en = 1'b0; wr_ch = '0; wr_note = '0; wr_mode = 1'b0;
    wr_duty = '0; en = '0; phase_rst = '0;
    repeat (3) @(negedge clk);
    checks++; if (wave !== 4'h0) begin failures++; $display("FAIL reset_wave got %h exp 0", wave); end
    checks++; if (mix !== 3'd0) begin failures++; $display("FAIL reset_mix got %0d exp 0", mix); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (wave !== 4'h0) begin failures++; $display("FAIL idle_wave got %h exp 0", wave); end
  endtask

  task automatic test_default_period();
    en[0] = 1'b1;
    @(negedge clk);
    checks++; if (wave[0] !== 1'b0) begin failures++; $display("FAIL en_edge_low got %b exp 0", wave[0]); end
    @(negedge clk);
    checks++; if (wave[0] !== 1'b1) begin failures++; $display("FAIL en_first_high got %b exp 1", wave[0]); end
    measure(0, 1'b1, hi, lo);
    checks++; if (hi !== 1136) begin failures++; $display("FAIL def_high got %0d exp 1136", hi); end
    checks++; if (lo !== 1136) begin failures++; $display("FAIL def_low got %0d exp 1136", lo); end
    measure(0, 1'b1, hi, lo);
    checks++; if (hi !== 1136) begin failures++; $display("FAIL def_high2 got %0d exp 1136", hi); end
    checks++; if (lo !== 1136) begin failures++; $display("FAIL def_low2 got %0d exp 1136", lo); end
  endtask

  task automatic test_retune();
    int highs;
    highs = 1;
    for (int i = 1; i < 2272; i++) begin
      if (i == 500) set_write(0, 57, 1'b0, 128);
      if (i == 501) wr_en = 1'b0;
      @(negedge clk);
      if (wave[0]) highs++;
    end
    checks++; if (highs !== 1136) begin failures++; $display("FAIL retune_old_high got %0d exp 1136", highs); end
    @(negedge clk);
    checks++; if (wave[0] !== 1'b1) begin failures++; $display("FAIL retune_boundary got %b exp 1", wave[0]); end
    measure(0, 1'b1, hi, lo);
    checks++; if (hi !== 2272) begin failures++; $display("FAIL retune_new_high got %0d exp 2272", hi); end
    checks++; if (lo !== 2273) begin failures++; $display("FAIL retune_new_low got %0d exp 2273", lo); end
  endtask

  task automatic test_square_clamp();
    set_write(1, 81, 1'b0, 128);
    @(negedge clk);
    wr_en = 1'b0;
    en[1] = 1'b1;
    measure(1, 1'b0, hi, lo);
    checks++; if (hi !== 568) begin failures++; $display("FAIL n81_high got %0d exp 568", hi); end
    checks++; if (lo !== 568) begin failures++; $display("FAIL n81_low got %0d exp 568", lo); end
    set_write(1, 10, 1'b0, 128);
    @(negedge clk);
    wr_en = 1'b0;
    measure(1, 1'b0, hi, lo);
    checks++; if (hi !== 18181) begin failures++; $display("FAIL clamp_high got %0d exp 18181", hi); end
    checks++; if (lo !== 18182) begin failures++; $display("FAIL clamp_low got %0d exp 18182", lo); end
  endtask

  task automatic test_pulse();
    int highs;
    set_write(2, 69, 1'b1, 64);
    @(negedge clk);
    wr_en = 1'b0;
    en[2] = 1'b1;
    measure(2, 1'b0, hi, lo);
    checks++; if (hi !== 568) begin failures++; $display("FAIL duty64_high got %0d exp 568", hi); end
    checks++; if (lo !== 1704) begin failures++; $display("FAIL duty64_low got %0d exp 1704", lo); end
    set_write(2, 69, 1'b1, 0);
    @(negedge clk);
    wr_en = 1'b0;
    repeat (2277) @(negedge clk);
    highs = 0;
    for (int i = 0; i < 2300; i++) begin
      @(negedge clk);
      if (wave[2]) highs++;
    end
    checks++; if (highs !== 0) begin failures++; $display("FAIL duty0_highs got %0d exp 0", highs); end
    set_write(2, 69, 1'b1, 255);
    @(negedge clk);
    wr_en = 1'b0;
    phase_rst[2] = 1'b1;
    @(negedge clk);
    phase_rst[2] = 1'b0;
    measure(2, 1'b0, hi, lo);
    checks++; if (hi !== 2263) begin failures++; $display("FAIL duty255_high got %0d exp 2263", hi); end
    checks++; if (lo !== 9) begin failures++; $display("FAIL duty255_low got %0d exp 9", lo); end
  endtask

  task automatic test_collision_reset();
    en[3] = 1'b1;
    repeat (1501) @(negedge clk);
    set_write(3, 81, 1'b0, 128);
    phase_rst[3] = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    phase_rst[3] = 1'b0;
    @(negedge clk);
    checks++; if (wave[3] !== 1'b0) begin failures++; $display("FAIL coll_restart_edge got %b exp 0", wave[3]); end
    @(negedge clk);
    checks++; if (wave[3] !== 1'b1) begin failures++; $display("FAIL coll_first_high got %b exp 1", wave[3]); end
    measure(3, 1'b1, hi, lo);
    checks++; if (hi !== 568) begin failures++; $display("FAIL coll_high got %0d exp 568", hi); end
    checks++; if (lo !== 568) begin failures++; $display("FAIL coll_low got %0d exp 568", lo); end
    rst = 1'b1;
    en = 4'b1000;
    set_write(3, 81, 1'b0, 128);
    phase_rst = 4'hF;
    @(negedge clk);
    checks++; if (wave !== 4'h0) begin failures++; $display("FAIL midrst_wave got %h exp 0", wave); end
    checks++; if (mix !== 3'd0) begin failures++; $display("FAIL midrst_mix got %0d exp 0", mix); end
    rst = 1'b0;
    wr_en = 1'b0;
    phase_rst = '0;
    measure(3, 1'b0, hi, lo);
    checks++; if (hi !== 1136) begin failures++; $display("FAIL postrst_high got %0d exp 1136", hi); end
    checks++; if (lo !== 1136) begin failures++; $display("FAIL postrst_low got %0d exp 1136", lo); end
  endtask

  task automatic test_mix();
    logic [3:0] exp_wave;
    logic [3:0] prev_wave;
    logic [2:0] exp_mix;
    int errs;
    rst = 1'b1;
    en = '0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    en = 4'hF;
    prev_wave = 4'h0;
    errs = 0;
    for (int k = 0; k <= 2273; k++) begin
      @(negedge clk);
      exp_wave = ((k >= 1 && k <= 1136) || k == 2273) ? 4'hF : 4'h0;
      exp_mix  = 3'($countones(prev_wave));
      if (wave !== exp_wave || mix !== exp_mix) errs++;
      if (k == 1) begin
        checks++; if (wave !== 4'hF) begin failures++; $display("FAIL mix_wave_on got %h exp f", wave); end
        checks++; if (mix !== 3'd0) begin failures++; $display("FAIL mix_lag_on got %0d exp 0", mix); end
      end
      if (k == 2) begin
        checks++; if (mix !== 3'd4) begin failures++; $display("FAIL mix_four got %0d exp 4", mix); end
      end
      if (k == 1137) begin
        checks++; if (wave !== 4'h0) begin failures++; $display("FAIL mix_wave_off got %h exp 0", wave); end
        checks++; if (mix !== 3'd4) begin failures++; $display("FAIL mix_lag_off got %0d exp 4", mix); end
      end
      if (k == 1138) begin
        checks++; if (mix !== 3'd0) begin failures++; $display("FAIL mix_zero got %0d exp 0", mix); end
      end
      prev_wave = exp_wave;
    end
    checks++; if (errs !== 0) begin failures++; $display("FAIL mix_track got %0d bad samples exp 0", errs); end
  endtask

  initial begin
    test_reset();
    test_default_period();
    test_retune();
    test_square_clamp();
    test_pulse();
    test_collision_reset();
    test_mix();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
